// File: rtl/axis_sequence_checker_if.sv
// AXI-Stream slave-side bundle for the sequence checker: data, valid, ready.
// The master drives tdata/tvalid; the checker returns a registered tready.
interface axis_sequence_checker_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_sequence_checker.sv
// Checks an AXI-Stream for the counting sequence 0..L and reports words seen, mismatches and completion.
// Latency: status updates one cycle after each handshake; a run starts two cycles after cfg_data goes non-zero.
// Backpressure: tready is a flop, high only in RUN; optional resync on mismatch via AXIS_SEQUENCE_CHECKER_RESYNC_EN.
module axis_sequence_checker #(
    parameter int    AXIS_TDATA_WIDTH = 32,
    parameter int    CNTR_WIDTH       = 32,
    parameter string CONTINUOUS       = "FALSE"
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CNTR_WIDTH-1:0] cfg_data,
    axis_sequence_checker_if.slave s_axis,
    output logic [CNTR_WIDTH-1:0] sts_count,
    output logic [CNTR_WIDTH-1:0] sts_errors,
    output logic                  sts_error,
    output logic                  sts_done
);

    localparam bit CONT_MODE = (CONTINUOUS == "TRUE");
    localparam logic [CNTR_WIDTH-1:0] CNT_MAX = {CNTR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                state_q,    state_d;
    logic [CNTR_WIDTH-1:0] cfg_q,      cfg_d;
    logic [CNTR_WIDTH-1:0] limit_q,    limit_d;
    logic [CNTR_WIDTH-1:0] expected_q, expected_d;
    logic [CNTR_WIDTH-1:0] count_q,    count_d;
    logic [CNTR_WIDTH-1:0] errors_q,   errors_d;
    logic                  error_q,    error_d;
    logic                  tready_q,   tready_d;

    logic                        hs;
    logic                        mismatch;
    logic [AXIS_TDATA_WIDTH-1:0] expected_ext;
    logic [CNTR_WIDTH-1:0]       base;

    always_comb begin
        expected_ext                 = '0;
        expected_ext[CNTR_WIDTH-1:0] = expected_q;
    end

    assign hs       = s_axis.tvalid & tready_q;
    assign mismatch = (s_axis.tdata != expected_ext);

    // Value the next expected word is derived from: the received word on a
    // mismatch when resyncing, otherwise the value we were looking for.
`ifdef AXIS_SEQUENCE_CHECKER_RESYNC_EN
    assign base = mismatch ? s_axis.tdata[CNTR_WIDTH-1:0] : expected_q;
`else
    assign base = expected_q;
`endif

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_data;
        limit_d    = limit_q;
        expected_d = expected_q;
        count_d    = count_q;
        errors_d   = errors_q;
        error_d    = error_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_q != '0) begin
                    state_d    = ST_RUN;
                    limit_d    = cfg_q;
                    expected_d = '0;
                    count_d    = '0;
                    errors_d   = '0;
                    error_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (hs) begin
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + CNTR_WIDTH'(1);
                    if (mismatch) begin
                        errors_d = (errors_q == CNT_MAX) ? errors_q : errors_q + CNTR_WIDTH'(1);
                        error_d  = 1'b1;
                    end
                    if (base < limit_q) begin
                        expected_d = base + CNTR_WIDTH'(1);
                    end else if (CONT_MODE) begin
                        expected_d = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (cfg_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            limit_q    <= '0;
            expected_q <= '0;
            count_q    <= '0;
            errors_q   <= '0;
            error_q    <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            limit_q    <= limit_d;
            expected_q <= expected_d;
            count_q    <= count_d;
            errors_q   <= errors_d;
            error_q    <= error_d;
            tready_q   <= tready_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign sts_count     = count_q;
    assign sts_errors    = errors_q;
    assign sts_error     = error_q;
    assign sts_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_axis_sequence_checker.sv
// Directed bench for axis_sequence_checker: stop-mode instance (u_dut1) and continuous instance (u_dut2).
module tb_axis_sequence_checker;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cfg1, cfg2;
    logic [31:0] cnt1, errs1, cnt2, errs2;
    logic        errf1, done1, errf2, done2;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axis_sequence_checker_if #(.DW(40)) s1 ();
    axis_sequence_checker_if #(.DW(40)) s2 ();

    axis_sequence_checker #(
        .AXIS_TDATA_WIDTH(40),
        .CNTR_WIDTH      (32),
        .CONTINUOUS      ("FALSE")
    ) u_dut1 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cfg_data  (cfg1),
        .s_axis    (s1),
        .sts_count (cnt1),
        .sts_errors(errs1),
        .sts_error (errf1),
        .sts_done  (done1)
    );

    axis_sequence_checker #(
        .AXIS_TDATA_WIDTH(40),
        .CNTR_WIDTH      (32),
        .CONTINUOUS      ("TRUE")
    ) u_dut2 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cfg_data  (cfg2),
        .s_axis    (s2),
        .sts_count (cnt2),
        .sts_errors(errs2),
        .sts_error (errf2),
        .sts_done  (done2)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drop(input int sel);
        if (sel == 1) s1.tvalid = 1'b0;
        else          s2.tvalid = 1'b0;
    endtask

    // Present one word after `gap` idle cycles and hold it until it is accepted.
    task automatic send_word(input int sel, input logic [39:0] d, input int gap);
        int   n;
        logic rdy;
        repeat (gap) begin
            drop(sel);
            tick();
        end
        if (sel == 1) begin s1.tdata = d; s1.tvalid = 1'b1; end
        else          begin s2.tdata = d; s2.tvalid = 1'b1; end
        n   = 0;
        rdy = (sel == 1) ? s1.tready : s2.tready;
        while (!rdy && n < 40) begin
            tick();
            n++;
            rdy = (sel == 1) ? s1.tready : s2.tready;
        end
        if (!rdy) check_val("hs_wait", {63'd0, rdy}, 64'd1);
        else      tick();
    endtask

    task automatic set_cfg(input int sel, input logic [31:0] v);
        if (sel == 1) cfg1 = v;
        else          cfg2 = v;
    endtask

    task automatic end_run(input int sel);
        drop(sel);
        set_cfg(sel, 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        aresetn   = 1'b0;
        cfg1      = '0;
        cfg2      = '0;
        s1.tdata  = '0;
        s1.tvalid = 1'b0;
        s2.tdata  = '0;
        s2.tvalid = 1'b0;
        repeat (3) tick();

        check_val("rst_tready", {63'd0, s1.tready}, 64'd0);
        check_val("rst_count",  {32'd0, cnt1}, 64'd0);
        check_val("rst_errors", {32'd0, errs1}, 64'd0);
        check_val("rst_error",  {63'd0, errf1}, 64'd0);
        check_val("rst_done",   {63'd0, done1}, 64'd0);
        check_val("rst_tready2", {63'd0, s2.tready}, 64'd0);
        aresetn = 1'b1;
        tick();

        // Basic stop-mode run 0..3 with tvalid held high.
        set_cfg(1, 32'd3);
        tick();
        tick();
        check_val("start_tready", {63'd0, s1.tready}, 64'd1);
        for (int i = 0; i < 4; i++) send_word(1, 40'(i), 0);
        check_val("t32_count",  {32'd0, cnt1}, 64'd4);
        check_val("t32_errors", {32'd0, errs1}, 64'd0);
        check_val("t32_done",   {63'd0, done1}, 64'd1);
        check_val("t32_tready", {63'd0, s1.tready}, 64'd0);
        s1.tdata = 40'd9;
        repeat (2) tick();
        check_val("done_no_accept", {32'd0, cnt1}, 64'd4);
        end_run(1);
        check_val("idle_done",  {63'd0, done1}, 64'd0);
        check_val("idle_hold",  {32'd0, cnt1}, 64'd4);

        // One bad word in the middle.
        set_cfg(1, 32'd3);
        send_word(1, 40'd0, 0);
        send_word(1, 40'd1, 0);
        send_word(1, 40'd5, 0);
        send_word(1, 40'd3, 0);
        drop(1);
        check_val("t33_errors", {32'd0, errs1}, 64'd1);
        check_val("t33_error",  {63'd0, errf1}, 64'd1);
        check_val("t33_done",   {63'd0, done1}, 64'd1);
        check_val("t33_count",  {32'd0, cnt1}, 64'd4);
        end_run(1);

        // Upper tdata bits beyond the counter width still count as a mismatch.
        set_cfg(1, 32'd1);
        send_word(1, 40'h80_0000_0000, 0);
        send_word(1, 40'd1, 0);
        drop(1);
        check_val("upper_errors", {32'd0, errs1}, 64'd1);
        check_val("upper_done",   {63'd0, done1}, 64'd1);
        end_run(1);

        // Skipped value: resync vs. free-running expected.
        set_cfg(1, 32'd5);
        tick();
        tick();
        check_val("t34_err_clr", {63'd0, errf1}, 64'd0);
        send_word(1, 40'd0, 0);
        send_word(1, 40'd1, 0);
        send_word(1, 40'd3, 0);
        send_word(1, 40'd4, 0);
        send_word(1, 40'd5, 0);
        drop(1);
        check_val("t34_count", {32'd0, cnt1}, 64'd5);
`ifdef AXIS_SEQUENCE_CHECKER_RESYNC_EN
        check_val("t34_errors", {32'd0, errs1}, 64'd1);
        check_val("t34_done",   {63'd0, done1}, 64'd1);
`else
        check_val("t34_errors", {32'd0, errs1}, 64'd3);
        check_val("t34_done",   {63'd0, done1}, 64'd0);
        check_val("t34_tready", {63'd0, s1.tready}, 64'd1);
        send_word(1, 40'd5, 0);
        drop(1);
        check_val("t34_fin_done",  {63'd0, done1}, 64'd1);
        check_val("t34_fin_count", {32'd0, cnt1}, 64'd6);
`endif
        end_run(1);

        // Continuous mode wraps and keeps counting.
        set_cfg(2, 32'd2);
        for (int i = 0; i < 6; i++) send_word(2, 40'(i % 3), 0);
        drop(2);
        check_val("t35_count",  {32'd0, cnt2}, 64'd6);
        check_val("t35_errors", {32'd0, errs2}, 64'd0);
        check_val("t35_done",   {63'd0, done2}, 64'd0);
        check_val("t35_tready", {63'd0, s2.tready}, 64'd1);
        send_word(2, 40'd0, 1);
        drop(2);
        check_val("t35_wrap",   {32'd0, errs2}, 64'd0);
        check_val("t35_count7", {32'd0, cnt2}, 64'd7);
        end_run(2);

        // Random gaps; cfg change mid-run must not shorten the run.
        set_cfg(1, 32'd7);
        for (int i = 0; i < 7; i++) begin
            send_word(1, 40'(i), int'($urandom_range(0, 3)));
            if (i == 2) set_cfg(1, 32'd2);
        end
        drop(1);
        repeat (2) tick();
        check_val("t36_done7",  {63'd0, done1}, 64'd0);
        check_val("t36_count7", {32'd0, cnt1}, 64'd7);
        send_word(1, 40'd7, 2);
        drop(1);
        check_val("t36_done",   {63'd0, done1}, 64'd1);
        check_val("t36_count",  {32'd0, cnt1}, 64'd8);
        check_val("t36_errors", {32'd0, errs1}, 64'd0);
        end_run(1);
        check_val("t36_idle",   {63'd0, done1}, 64'd0);
        check_val("t36_idle_rdy", {63'd0, s1.tready}, 64'd0);

        // Reset mid-run aborts; held cfg restarts from zero.
        set_cfg(1, 32'd3);
        send_word(1, 40'd0, 0);
        send_word(1, 40'd1, 0);
        s1.tdata = 40'd2;
        aresetn  = 1'b0;
        tick();
        check_val("t37_count",  {32'd0, cnt1}, 64'd0);
        check_val("t37_tready", {63'd0, s1.tready}, 64'd0);
        check_val("t37_done",   {63'd0, done1}, 64'd0);
        check_val("t37_errors", {32'd0, errs1}, 64'd0);
        aresetn = 1'b1;
        drop(1);
        for (int i = 0; i < 4; i++) send_word(1, 40'(i), 0);
        drop(1);
        check_val("t37_rerun_errors", {32'd0, errs1}, 64'd0);
        check_val("t37_rerun_count",  {32'd0, cnt1}, 64'd4);
        check_val("t37_rerun_done",   {63'd0, done1}, 64'd1);
        end_run(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
